// File: rtl/deb_pkg.sv
// Shared definitions for the debounce interval timer arbiter: FSM encoding,
// the nominal 300 ms interval and default widths.
package deb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } deb_state_e;

  // 300 ms at 50 MHz
  localparam int DEB_COUNT_300MS = 15000000;
  localparam int DEB_CNT_W       = 24;

  // Index width that stays legal for a single requester.
  function automatic int deb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_selector.sv
// Combinational round-robin pick: first set req bit strictly after pointer,
// wrapping around, returned as one-hot, index and an any-request flag.
module rr_selector
  import deb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = deb_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    sel   = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    // i = N_REQ lands on the pointer itself, so it has lowest priority
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(pointer) + i) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        sel[cand] = 1'b1;
        index     = cand;
      end
    end
  end

endmodule

// File: rtl/debounce_timer_arbiter.sv
// One long interval counter shared round-robin among N_REQ debouncers; the
// granted requester gets a one-cycle done pulse when its interval expires.
module debounce_timer_arbiter
  import deb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int COUNT_MAX = DEB_COUNT_300MS,
  parameter int CNT_W     = DEB_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  localparam int               IDX_W    = deb_idx_w(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;

  logic [N_REQ-1:0] rr_sel;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_any;

  rr_selector #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_selector (
    .req     (req),
    .pointer (ptr_q),
    .sel     (rr_sel),
    .index   (rr_idx),
    .any     (rr_any)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= PTR_INIT;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;

    unique case (state_q)
      IDLE: begin
        if (rr_any) begin
          grant_d = rr_sel;
          gidx_d  = rr_idx;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = COUNT;
        end
      end

      COUNT: begin
        // Abandoning the request beats expiry, even on the terminal edge
        if (!req[gidx_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_d  = grant_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        ptr_d   = gidx_q;
        state_d = IDLE;
      end

      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Directed bench for debounce_timer_arbiter with a short 8-cycle interval.
module tb_debounce_timer_arbiter;

  localparam int N   = 4;
  localparam int CMX = 8;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  debounce_timer_arbiter #(
    .N_REQ     (N),
    .COUNT_MAX (CMX),
    .CNT_W     (4)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .req   (req),
    .done  (done),
    .grant (grant),
    .busy  (busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [N-1:0] eg, input logic [N-1:0] ed,
                       input logic eb);
    n_vec++;
    if (grant !== eg || done !== ed || busy !== eb) begin
      n_err++;
      $display("FAIL %s: got grant=%b done=%b busy=%b, want grant=%b done=%b busy=%b",
               nm, grant, done, busy, eg, ed, eb);
    end
  endtask

  task automatic push(input logic [N-1:0] r, input logic [N-1:0] g, input logic [N-1:0] d,
                      input logic b, input int n);
    vec_t v;
    v.req = r; v.grant = g; v.done = d; v.busy = b;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  // Grant edge plus seven counting edges, then the edge that raises done.
  task automatic interval(input logic [N-1:0] r, input logic [N-1:0] g);
    push(r, g, 4'b0000, 1'b1, CMX);
    push(r, g, g, 1'b1, 1);
  endtask

  initial begin
    Rst_n = 1'b0;
    req   = '0;

    // Single request from reset, then simultaneous 1010, then wrap with 1001
    interval(4'b0001, 4'b0001);
    push(4'b0000, 4'b0000, 4'b0000, 1'b0, 2);
    interval(4'b1010, 4'b0010);
    push(4'b1000, 4'b0000, 4'b0000, 1'b0, 1);
    interval(4'b1000, 4'b1000);
    push(4'b0000, 4'b0000, 4'b0000, 1'b0, 2);
    interval(4'b1001, 4'b0001);
    push(4'b1001, 4'b0000, 4'b0000, 1'b0, 1);
    interval(4'b1001, 4'b1000);
    push(4'b0000, 4'b0000, 4'b0000, 1'b0, 2);

    #12;
    check("reset", 4'b0000, 4'b0000, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    step();
    check("idle_after_reset", 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      step();
      check($sformatf("tbl[%0d]", i), tbl[i].grant, tbl[i].done, tbl[i].busy);
    end

    // Abort: requester 2 drops at cnt=4, pending 1 and 3; pointer still 3 so 1 wins
    req = 4'b0100;
    step();
    check("abort_grant2", 4'b0100, 4'b0000, 1'b1);
    req = 4'b1110;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("abort_cnt%0d", k), 4'b0100, 4'b0000, 1'b1);
    end
    req = 4'b1010;
    step();
    check("abort_drop", 4'b0000, 4'b0000, 1'b0);
    step();
    check("abort_next_grant1", 4'b0010, 4'b0000, 1'b1);
    for (int k = 1; k < CMX; k++) begin
      step();
      check($sformatf("g1_cnt%0d", k), 4'b0010, 4'b0000, 1'b1);
    end
    step();
    check("g1_done", 4'b0010, 4'b0010, 1'b1);
    req = 4'b1000;
    step();
    check("g1_exit", 4'b0000, 4'b0000, 1'b0);

    // Reset mid-count clears outputs without a clock edge
    step();
    check("rst_grant3", 4'b1000, 4'b0000, 1'b1);
    step();
    step();
    #2;
    Rst_n = 1'b0;
    #1;
    check("rst_async_clear", 4'b0000, 4'b0000, 1'b0);
    req   = 4'b1111;
    #1;
    Rst_n = 1'b1;
    step();
    check("rst_release_grant0", 4'b0001, 4'b0000, 1'b1);

    // Terminal-edge abort: drop req[0] while cnt=7
    for (int k = 1; k < CMX; k++) begin
      step();
      check($sformatf("term_cnt%0d", k), 4'b0001, 4'b0000, 1'b1);
    end
    req = 4'b0000;
    step();
    check("term_abort", 4'b0000, 4'b0000, 1'b0);
    step();
    check("term_idle", 4'b0000, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_timer_arbiter.md
Name: debounce_timer_arbiter

Overview:
- Shares one debounce interval timer (nominal 300 ms) among N_REQ button debouncers.
- Each debouncer raises its count-enable request while it waits for its interval to expire.
- The arbiter grants the timer round-robin, counts COUNT_MAX cycles, then returns a one-cycle expiry pulse to the granted requester only.
- Sits between the debouncer bank and the rest of the design, so only one long counter is needed.

Parameters:
- N_REQ, 4: number of requesting debouncers.
- COUNT_MAX, 15000000: interval length in Clk cycles (300 ms at 50 MHz). Must be at least 2.
- CNT_W, 24: counter width. Must satisfy 2^CNT_W > COUNT_MAX.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-debouncer count request. Level; held until done or abandoned.
- done  output  N_REQ  per-debouncer interval-expired pulse. One-hot or zero, one cycle wide.
- grant  output  N_REQ  requester currently owning the timer. One-hot or zero.
- busy  output  1  timer in use (state COUNT or DONE).

Behaviour:
- Reset is asynchronous, active-low, one clock domain.
- Reset values:
  - state = IDLE, cnt = 0.
  - grant = 0, done = 0, busy = 0.
  - last-grant pointer = N_REQ-1, so req[0] has first priority after reset.
- All outputs are registered. There are no combinational paths from req to any output.
- State IDLE:
  - If req == 0: stay in IDLE.
  - Otherwise: select the first set req bit, searching upward from pointer+1 with wrap-around.
  - On the same edge: grant <= onehot(sel), cnt <= 0, busy <= 1, state <= COUNT.
- State COUNT:
  - Abort check has priority. If req[g] == 0 (g = granted index): grant <= 0, busy <= 0, cnt <= 0, state <= IDLE. No done pulse; pointer unchanged.
  - Otherwise, if cnt == COUNT_MAX-1: state <= DONE and done[g] <= 1. grant is held.
  - Otherwise: cnt <= cnt+1.
- State DONE (exactly one cycle):
  - done[g] is high during this cycle.
  - On exit: done <= 0, grant <= 0, busy <= 0, pointer <= g, state <= IDLE.
  - If req[g] is still high here, it is ignored. It competes again in IDLE like any other request.
- Latency:
  - Let edge E0 be the edge where IDLE samples req.
  - grant is visible after E0.
  - done is visible after E0 + COUNT_MAX edges, for one cycle.
  - Minimum gap between consecutive grants is one IDLE cycle.
- Fairness:
  - The pointer is updated only on successful completion.
  - A requester holding req waits at most (N_REQ-1) × (COUNT_MAX+2) cycles.
- Simultaneous events:
  - Several req bits rising on the same edge: resolved by round-robin order.
  - New requests arriving during COUNT or DONE: queued implicitly by holding req; never preempt.
  - req[g] dropping on the terminal-count edge: abort wins, no done.
- Reset mid-operation clears everything immediately, with no done pulse.
- The counter never exceeds COUNT_MAX-1 and never wraps.
- Undefined state encodings go to IDLE with outputs cleared.

Decomposition:
- Shared package (deb_pkg):
  - State encoding: IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2.
  - DEB_COUNT_300MS constant (15000000).
  - Default CNT_W.
- One sub-module: rr_selector.
  - Combinational. Inputs: req, pointer.
  - Outputs: one-hot sel, index, any.
  - The arbiter FSM instantiates it once.

Test Plan (bench overrides COUNT_MAX = 8):
- Single request: req = 4'b0001 held → grant = 0001 one cycle later; done = 0001 exactly 8 edges after the sampling edge, one cycle wide; busy falls the cycle after done.
- Simultaneous requests: req = 4'b1010 from reset, held until each bit's done → grants in order 0010 then 1000; each done pulse one-hot and matching its grant; one IDLE cycle between grants.
- Round-robin wrap: pointer = 3 after completing requester 3, then req = 4'b1001 → requester 0 granted before requester 3.
- Abort: req[2] dropped at cnt = 4 → grant = 0 next cycle, no done pulse, pointer unchanged; pending req[1] granted next.
- Reset mid-count: Rst_n low during COUNT → grant, done, busy = 0 asynchronously; after release with req = 4'b1111, requester 0 granted first.
- Terminal-edge abort: req[g] deasserted in the cnt = 7 cycle → no done pulse, FSM returns to IDLE.
